// File: rtl/udp_port_dispatch.sv
// rtl/udp_port_dispatch.sv - UDP receive dispatcher steering frames to CHANNELS destination-port channels.
// Optional feature macro: UDP_PORT_DISPATCH_DEFAULT_EN (unmatched frames go to the last channel).
module udp_port_dispatch #(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_udp_hdr_valid,
    output logic                     s_udp_hdr_ready,
    input  logic [31:0]              s_udp_ip_source_ip,
    input  logic [15:0]              s_udp_source_port,
    input  logic [15:0]              s_udp_dest_port,
    input  logic [15:0]              s_udp_length,
    input  logic [DATA_WIDTH-1:0]    s_udp_payload_axis_tdata,
    input  logic                     s_udp_payload_axis_tvalid,
    output logic                     s_udp_payload_axis_tready,
    input  logic                     s_udp_payload_axis_tlast,
    input  logic                     s_udp_payload_axis_tuser,
    output logic [CHANNELS-1:0]      m_udp_hdr_valid,
    input  logic [CHANNELS-1:0]      m_udp_hdr_ready,
    output logic [31:0]              m_udp_ip_source_ip,
    output logic [15:0]              m_udp_source_port,
    output logic [15:0]              m_udp_dest_port,
    output logic [15:0]              m_udp_length,
    output logic [DATA_WIDTH-1:0]    m_udp_payload_axis_tdata,
    output logic [CHANNELS-1:0]      m_udp_payload_axis_tvalid,
    input  logic [CHANNELS-1:0]      m_udp_payload_axis_tready,
    output logic                     m_udp_payload_axis_tlast,
    output logic                     m_udp_payload_axis_tuser,
    input  logic [CHANNELS*16-1:0]   cfg_port,
    input  logic [CHANNELS-1:0]      cfg_port_en,
    output logic [CNT_WIDTH-1:0]     status_drop_count
);

    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [31:0]          src_ip_q, src_ip_d;
    logic [15:0]          src_port_q, src_port_d;
    logic [15:0]          dst_port_q, dst_port_d;
    logic [15:0]          length_q, length_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic                 match_found;
    logic [SEL_W-1:0]     match_idx;
    logic [CHANNELS-1:0]  sel_oh;
    logic                 hdr_hs;
    logic                 last_hs;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (cfg_port_en[i] && (cfg_port[16*i +: 16] == s_udp_dest_port)) begin
                match_found = 1'b1;
                match_idx   = SEL_W'(i);
            end
        end
    end

    always_comb begin
        sel_oh        = '0;
        sel_oh[sel_q] = 1'b1;
    end

    assign hdr_hs  = s_udp_hdr_valid && (state_q == ST_IDLE);
    assign last_hs = s_udp_payload_axis_tvalid && s_udp_payload_axis_tready
                     && s_udp_payload_axis_tlast;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        src_ip_d   = src_ip_q;
        src_port_d = src_port_q;
        dst_port_d = dst_port_q;
        length_d   = length_q;
        drop_cnt_d = drop_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (hdr_hs) begin
                    src_ip_d   = s_udp_ip_source_ip;
                    src_port_d = s_udp_source_port;
                    dst_port_d = s_udp_dest_port;
                    length_d   = s_udp_length;
                    if (match_found) begin
                        sel_d   = match_idx;
                        state_d = ST_HDR;
                    end else begin
`ifdef UDP_PORT_DISPATCH_DEFAULT_EN
                        sel_d   = SEL_W'(CHANNELS - 1);
                        state_d = ST_HDR;
`else
                        state_d = ST_DROP;
                        if (drop_cnt_q != '1) begin
                            drop_cnt_d = drop_cnt_q + 1'b1;
                        end
`endif
                    end
                end
            end
            ST_HDR: begin
                if (m_udp_hdr_ready[sel_q]) begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD, ST_DROP: begin
                if (last_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            src_ip_q   <= '0;
            src_port_q <= '0;
            dst_port_q <= '0;
            length_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            src_ip_q   <= src_ip_d;
            src_port_q <= src_port_d;
            dst_port_q <= dst_port_d;
            length_q   <= length_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Outputs decode straight from state/sel flops; payload path is zero-latency.
    assign s_udp_hdr_ready   = (state_q == ST_IDLE);
    assign m_udp_hdr_valid   = (state_q == ST_HDR) ? sel_oh : '0;
    assign m_udp_payload_axis_tvalid =
        ((state_q == ST_PAYLOAD) && s_udp_payload_axis_tvalid) ? sel_oh : '0;
    assign s_udp_payload_axis_tready =
        (state_q == ST_PAYLOAD) ? m_udp_payload_axis_tready[sel_q] :
        (state_q == ST_DROP);

    assign m_udp_ip_source_ip       = src_ip_q;
    assign m_udp_source_port        = src_port_q;
    assign m_udp_dest_port          = dst_port_q;
    assign m_udp_length             = length_q;
    assign m_udp_payload_axis_tdata = s_udp_payload_axis_tdata;
    assign m_udp_payload_axis_tlast = s_udp_payload_axis_tlast;
    assign m_udp_payload_axis_tuser = s_udp_payload_axis_tuser;
    assign status_drop_count        = drop_cnt_q;

endmodule
